// File: rtl/sram_init_hold_ctrl.sv
// -----------------------------------------------------------------------------
// sram_init_hold_ctrl
//   Control stage in front of a DEPTH x WIDTH one-read/one-write SRAM macro
//   with 1-cycle read latency. After reset it writes zero to every entry, then
//   arbitrates requester reads/writes onto the macro ports. The last read
//   result is held stable until the next accepted read.
//
//   Optional feature macro: SRAM_CTRL_BYPASS_EN
//     defined   : a same-address read+write is accepted; the read returns the
//                 write data through registered bypass storage.
//     undefined : a same-address read is refused (r_req_ready=0) so the write
//                 wins and the requester retries next cycle.
//
// Ports:
//   clock, reset                  clock / async active-high reset
//   r_req_valid/ready/addr        read request handshake
//   r_resp_valid/data             read response (1-cycle latency, held data)
//   w_req_valid/ready/addr/data   write request handshake
//   init_done                     high once all entries are zeroed
//   arr_r_en/addr, arr_r_data     macro read port
//   arr_w_en/addr/data/mask       macro write port (mask tied to 1)
// -----------------------------------------------------------------------------
module sram_init_hold_ctrl #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int WIDTH  = 51
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_addr,
  output logic              r_resp_valid,
  output logic [WIDTH-1:0]  r_resp_data,
  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic [ADDR_W-1:0] w_req_addr,
  input  logic [WIDTH-1:0]  w_req_data,
  output logic              init_done,
  output logic              arr_r_en,
  output logic [ADDR_W-1:0] arr_r_addr,
  input  logic [WIDTH-1:0]  arr_r_data,
  output logic              arr_w_en,
  output logic [ADDR_W-1:0] arr_w_addr,
  output logic [WIDTH-1:0]  arr_w_data,
  output logic              arr_w_mask
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_init_cnt;
  logic [ADDR_W-1:0]   w_init_cnt_nxt;
  logic                r_init_done;
  logic                w_init_done_nxt;
  logic                r_resp_pend;
  logic [WIDTH-1:0]    r_hold;
  logic                w_collision;
  logic [WIDTH-1:0]    w_rd_resolved;

  assign w_collision = r_req_valid && w_req_valid && (r_req_addr == w_req_addr);
  assign arr_w_mask  = 1'b1;
  assign init_done   = r_init_done;

`ifdef SRAM_CTRL_BYPASS_EN
  logic                r_byp;
  logic [WIDTH-1:0]    r_byp_data;

  // Bypass storage: remember that the accepted read collided with a write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_byp      <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_byp <= arr_r_en && w_collision;
      if (arr_r_en && w_collision) begin
        r_byp_data <= w_req_data;
      end else begin
        r_byp_data <= r_byp_data;
      end
    end
  end

  // The macro returns pre-write data on a collision, so substitute the write
  assign w_rd_resolved = r_byp ? r_byp_data : arr_r_data;
`else
  assign w_rd_resolved = arr_r_data;
`endif

  // Next-state and macro/handshake drive
  always_comb begin
    w_state_nxt     = r_state;
    w_init_cnt_nxt  = r_init_cnt;
    w_init_done_nxt = r_init_done;
    r_req_ready     = 1'b0;
    w_req_ready     = 1'b0;
    arr_r_en        = 1'b0;
    arr_r_addr      = r_req_addr;
    arr_w_en        = 1'b0;
    arr_w_addr      = w_req_addr;
    arr_w_data      = w_req_data;
    case (r_state)
      ST_INIT: begin
        // No macro write while reset is held; the sweep starts on release
        arr_w_en   = ~reset;
        arr_w_addr = r_init_cnt;
        arr_w_data = '0;
        if (r_init_cnt == LAST_ADDR) begin
          w_state_nxt     = ST_RUN;
          w_init_done_nxt = 1'b1;
        end else begin
          w_init_cnt_nxt = r_init_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        w_req_ready = 1'b1;
`ifdef SRAM_CTRL_BYPASS_EN
        r_req_ready = 1'b1;
`else
        r_req_ready = ~w_collision;
`endif
        arr_r_en = r_req_valid && r_req_ready;
        arr_w_en = w_req_valid;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // State, init sweep counter and init_done registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_init_cnt_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  // Response valid pipeline and held read result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_resp_pend <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_resp_pend <= arr_r_en;
      if (r_resp_pend) begin
        r_hold <= w_rd_resolved;
      end else begin
        r_hold <= r_hold;
      end
    end
  end

  assign r_resp_valid = r_resp_pend;
  assign r_resp_data  = r_resp_pend ? w_rd_resolved : r_hold;

endmodule
